video_timing_gen: RTL and testbench

Generates the native-rate (15 kHz-class) video stream consumed by the scandoubler input side.
- Outputs: pixel clock-enable, sync, blanking and RGB, plus pixel coordinates and a fetch request towards the pixel source (framebuffer or line buffer).
- All outputs are registered and mutually aligned, so the scandoubler measures pixel length and line timing from them directly.
- One clock domain: clk_vid.

---
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_timing_gen.sv | 110 +++++++++++
 tb/tb_video_timing_gen.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Native-rate video bus between the timing generator, its pixel source and the scandoubler.
// The master side is the timing generator; the slave side supplies pixels and consumes video.
interface video_timing_gen_if #(
  parameter int HALF_DEPTH = 0
);
  localparam int DWIDTH = HALF_DEPTH ? 3 : 5;

  logic [3*(DWIDTH+1)-1:0] pix_rgb_in;
  logic                    pix_req;
  logic [9:0]              pix_x;
  logic [9:0]              pix_y;
  logic                    ce_pix;
  logic                    hs_out;
  logic                    vs_out;
  logic                    hb_out;
  logic                    vb_out;
  logic [DWIDTH:0]         r_out;
  logic [DWIDTH:0]         g_out;
  logic [DWIDTH:0]         b_out;
  logic                    frame_start;

  modport master (
    input  pix_rgb_in,
    output pix_req, pix_x, pix_y, ce_pix, hs_out, vs_out, hb_out, vb_out,
           r_out, g_out, b_out, frame_start
  );

  modport slave (
    output pix_rgb_in,
    input  pix_req, pix_x, pix_y, ce_pix, hs_out, vs_out, hb_out, vb_out,
           r_out, g_out, b_out, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// 15 kHz-class video timing generator: pixel strobe, sync/blank, coordinates and black-forced RGB,
// all registered and aligned so a downstream scandoubler can measure timing straight off the pins.
module video_timing_gen #(
  parameter int CE_DIV     = 4,
  parameter int H_ACTIVE   = 320,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 240,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 16,
  parameter int HALF_DEPTH = 0
) (
  input  logic               clk_vid,
  input  logic               reset,
  input  logic               enable,
  video_timing_gen_if.master vid
);
  localparam int DWIDTH  = HALF_DEPTH ? 3 : 5;
  localparam int CW      = DWIDTH + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [7:0] DIV_LAST = 8'(CE_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [7:0] div;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] hcnt_next;
  logic [9:0] vcnt_next;
  logic       tick;
  logic       active_now;
  logic       active_next;

  assign tick        = enable && (div == DIV_LAST);
  assign active_now  = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign active_next = (hcnt_next < H_ACT) && (vcnt_next < V_ACT);
  assign vid.pix_x   = hcnt;
  assign vid.pix_y   = vcnt;

  always_comb begin
    hcnt_next = hcnt + 10'd1;
    vcnt_next = vcnt;
    if (hcnt == H_LAST) begin
      hcnt_next = '0;
      vcnt_next = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end
  end

  // Divider runs only while enabled, so a pause resumes mid-pixel without dropping one.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (enable) begin
        div <= (div == DIV_LAST) ? '0 : div + 8'd1;
      end
      if (tick) begin
        hcnt <= hcnt_next;
        vcnt <= vcnt_next;
      end
    end
  end

  // Outputs load the decode of the position being left, in the same edge the counters advance.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      vid.ce_pix      <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.hs_out      <= 1'b0;
      vid.vs_out      <= 1'b0;
      vid.hb_out      <= 1'b1;
      vid.vb_out      <= 1'b1;
      vid.pix_req     <= 1'b1;
      vid.r_out       <= '0;
      vid.g_out       <= '0;
      vid.b_out       <= '0;
    end else begin
      vid.ce_pix      <= tick;
      vid.frame_start <= tick && (hcnt == '0) && (vcnt == '0);
      if (tick) begin
        vid.hb_out  <= hcnt >= H_ACT;
        vid.hs_out  <= (hcnt >= HS_START) && (hcnt < HS_END);
        vid.vb_out  <= vcnt >= V_ACT;
        vid.vs_out  <= (vcnt >= VS_START) && (vcnt < VS_END);
        vid.pix_req <= active_next;
        if (active_now) begin
          vid.r_out <= vid.pix_rgb_in[CW-1:0];
          vid.g_out <= vid.pix_rgb_in[2*CW-1:CW];
          vid.b_out <= vid.pix_rgb_in[3*CW-1:2*CW];
        end else begin
          vid.r_out <= '0;
          vid.g_out <= '0;
          vid.b_out <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: default-geometry instance for line timing, data path, pause and reset,
// plus a small CE_DIV=2 / 4-bit instance fed by a registered source for whole-frame timing.
module tb_video_timing_gen;
  localparam int A_HA = 320, A_HFP = 16, A_HS = 32, A_HT = 416;
  localparam int A_VA = 240, A_VFP = 3, A_VS = 3, A_VT = 262;
  localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HBP = 2, B_HT = 15;
  localparam int B_VA = 4, B_VFP = 1, B_VS = 2, B_VBP = 1, B_VT = 8;
  localparam logic [43:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0, 20'd0, 1'b1};

  typedef struct {
    int   h, v, nx, ny, r, g, b;
    logic hs, hb, vs, vb, fs, nreq;
  } exp_t;

  logic clk_vid;
  logic reset_a, reset_b, enable_a, enable_b;
  logic [11:0] rgb_b_q;
  int   n_checks, n_fail;
  int   pa_h, pa_v, pb_h, pb_v;
  exp_t qa[$];
  exp_t qb[$];

  video_timing_gen_if #(.HALF_DEPTH(0)) vif_a ();
  video_timing_gen_if #(.HALF_DEPTH(1)) vif_b ();

  video_timing_gen dut_a (
    .clk_vid (clk_vid),
    .reset   (reset_a),
    .enable  (enable_a),
    .vid     (vif_a.master)
  );

  video_timing_gen #(
    .CE_DIV(2), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .HALF_DEPTH(1)
  ) dut_b (
    .clk_vid (clk_vid),
    .reset   (reset_b),
    .enable  (enable_b),
    .vid     (vif_b.master)
  );

  assign vif_a.pix_rgb_in = {vif_a.pix_y[5:0], vif_a.pix_x[5:0], 6'h2A};

  // One-cycle-latency pixel source for the small instance, like a synchronous RAM.
  always @(posedge clk_vid) rgb_b_q <= {vif_b.pix_y[3:0], vif_b.pix_x[3:0], 4'h5};
  assign vif_b.pix_rgb_in = rgb_b_q;

  initial clk_vid = 1'b0;
  always #5 clk_vid = ~clk_vid;

  function automatic exp_t make_exp(input int h, v, ha, hfp, hsw, ht, va, vfp, vsw, vt,
                                    input int rconst, cmask);
    exp_t e;
    logic act;
    act    = (h < ha) && (v < va);
    e.h    = h;
    e.v    = v;
    e.hb   = h >= ha;
    e.hs   = (h >= ha + hfp) && (h < ha + hfp + hsw);
    e.vb   = v >= va;
    e.vs   = (v >= va + vfp) && (v < va + vfp + vsw);
    e.fs   = (h == 0) && (v == 0);
    e.r    = act ? rconst : 0;
    e.g    = act ? (h & cmask) : 0;
    e.b    = act ? (v & cmask) : 0;
    e.nx   = (h == ht - 1) ? 0 : h + 1;
    e.ny   = (h == ht - 1) ? ((v == vt - 1) ? 0 : v + 1) : v;
    e.nreq = (e.nx < ha) && (e.ny < va);
    return e;
  endfunction

  function automatic logic [43:0] exp_vec(input exp_t e);
    return {e.hs, e.hb, e.vs, e.vb, e.fs, 6'(e.r), 6'(e.g), 6'(e.b), 10'(e.nx), 10'(e.ny), e.nreq};
  endfunction

  function logic [43:0] obs_a();
    return {vif_a.hs_out, vif_a.hb_out, vif_a.vs_out, vif_a.vb_out, vif_a.frame_start,
            vif_a.r_out, vif_a.g_out, vif_a.b_out, vif_a.pix_x, vif_a.pix_y, vif_a.pix_req};
  endfunction

  function logic [43:0] obs_b();
    return {vif_b.hs_out, vif_b.hb_out, vif_b.vs_out, vif_b.vb_out, vif_b.frame_start,
            2'b00, vif_b.r_out, 2'b00, vif_b.g_out, 2'b00, vif_b.b_out,
            vif_b.pix_x, vif_b.pix_y, vif_b.pix_req};
  endfunction

  task automatic push_a();
    exp_t e;
    e = make_exp(pa_h, pa_v, A_HA, A_HFP, A_HS, A_HT, A_VA, A_VFP, A_VS, A_VT, 'h2A, 63);
    qa.push_back(e);
    pa_h = e.nx;
    pa_v = e.ny;
  endtask

  task automatic push_b();
    exp_t e;
    e = make_exp(pb_h, pb_v, B_HA, B_HFP, B_HS, B_HT, B_VA, B_VFP, B_VS, B_VT, 5, 15);
    qb.push_back(e);
    pb_h = e.nx;
    pb_v = e.ny;
  endtask

  task automatic wait_ce(input bit use_b, input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (!ok && cycles < limit) begin
      @(negedge clk_vid);
      cycles++;
      if ((use_b ? vif_b.ce_pix : vif_a.ce_pix) === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ce_timeout: got no ce_pix in %0d cycles, required one", limit);
    end
  endtask

  task automatic test_reset();
    logic [44:0] got;
    repeat (3) @(negedge clk_vid);
    got = {vif_a.ce_pix, obs_a()};
    n_checks++;
    if (got !== {1'b0, RST_VEC}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h, required %h", got, {1'b0, RST_VEC});
    end
  endtask

  task automatic test_first_ce();
    int cyc;
    bit ok;
    exp_t e;
    qa.delete();
    pa_h = 0;
    pa_v = 0;
    reset_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_a();
      wait_ce(1'b0, 20, cyc, ok);
      e = qa.pop_front();
      n_checks++;
      if (cyc !== 4) begin
        n_fail++;
        $display("[TB] FAIL ce_spacing[%0d]: got %0d cycles, required 4", i, cyc);
      end
      n_checks++;
      if (obs_a() !== exp_vec(e)) begin
        n_fail++;
        $display("[TB] FAIL start_pixel[%0d]: got %h, required %h", i, obs_a(), exp_vec(e));
      end
    end
  endtask

  task automatic test_horizontal();
    int cyc, hb_rise_h, hb_fall_idx, hs_count, hs_first;
    bit ok, done, prev_hb;
    exp_t e;
    hb_rise_h   = -1;
    hb_fall_idx = -1;
    hs_count    = 0;
    hs_first    = -1;
    done        = 1'b0;
    prev_hb     = vif_a.hb_out;
    for (int i = 4; i < 500 && !done; i++) begin
      push_a();
      wait_ce(1'b0, 20, cyc, ok);
      e = qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_vec(e)) begin
        n_fail++;
        $display("[TB] FAIL line_pixel(%0d,%0d): got %h, required %h", e.h, e.v, obs_a(), exp_vec(e));
      end
      if (vif_a.hb_out && !prev_hb) hb_rise_h = e.h;
      if (!vif_a.hb_out && prev_hb) begin
        hb_fall_idx = i;
        done        = 1'b1;
      end
      if (vif_a.hs_out) begin
        if (hs_first < 0) hs_first = e.h;
        hs_count++;
      end
      prev_hb = vif_a.hb_out;
    end
    n_checks++;
    if (hb_rise_h !== 320) begin
      n_fail++;
      $display("[TB] FAIL hb_rise_h: got %0d, required 320", hb_rise_h);
    end
    n_checks++;
    if (hb_fall_idx !== 416) begin
      n_fail++;
      $display("[TB] FAIL line_length: got %0d, required 416", hb_fall_idx);
    end
    n_checks++;
    if (hs_count !== 32) begin
      n_fail++;
      $display("[TB] FAIL hs_width: got %0d, required 32", hs_count);
    end
    n_checks++;
    if (hs_first !== 336) begin
      n_fail++;
      $display("[TB] FAIL hs_start: got %0d, required 336", hs_first);
    end
  endtask

  task automatic test_data_path();
    int cyc, blank_nz, req_bad;
    bit ok, hit;
    exp_t e;
    blank_nz = 0;
    req_bad  = 0;
    hit      = 1'b0;
    for (int i = 0; i < 7 * A_HT + 10 && !hit; i++) begin
      push_a();
      wait_ce(1'b0, 20, cyc, ok);
      e = qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_vec(e)) begin
        n_fail++;
        $display("[TB] FAIL data_pixel(%0d,%0d): got %h, required %h", e.h, e.v, obs_a(), exp_vec(e));
      end
      if ((vif_a.hb_out || vif_a.vb_out) && ({vif_a.r_out, vif_a.g_out, vif_a.b_out} != 18'd0))
        blank_nz++;
      if (vif_a.pix_req && vif_a.pix_x >= 10'd320) req_bad++;
      if (e.h == 5 && e.v == 7) begin
        hit = 1'b1;
        n_checks++;
        if ({vif_a.r_out, vif_a.g_out, vif_a.b_out} !== {6'h2A, 6'd5, 6'd7}) begin
          n_fail++;
          $display("[TB] FAIL rgb_at_5_7: got %h, required %h",
                   {vif_a.r_out, vif_a.g_out, vif_a.b_out}, {6'h2A, 6'd5, 6'd7});
        end
      end
    end
    n_checks++;
    if (blank_nz !== 0) begin
      n_fail++;
      $display("[TB] FAIL blank_black: got %0d coloured blank pixels, required 0", blank_nz);
    end
    n_checks++;
    if (req_bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL req_in_hblank: got %0d, required 0", req_bad);
    end
  endtask

  task automatic test_enable_freeze();
    int cyc;
    bit ok;
    exp_t e;
    exp_t last;
    for (int i = 0; i < 55; i++) begin
      push_a();
      wait_ce(1'b0, 20, cyc, ok);
      last = qa.pop_front();
      n_checks++;
      if (obs_a() !== exp_vec(last)) begin
        n_fail++;
        $display("[TB] FAIL pre_pause(%0d,%0d): got %h, required %h", last.h, last.v, obs_a(), exp_vec(last));
      end
    end
    repeat (2) @(negedge clk_vid);
    enable_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_vid);
      n_checks++;
      if ({vif_a.ce_pix, obs_a()} !== {1'b0, exp_vec(last)}) begin
        n_fail++;
        $display("[TB] FAIL paused[%0d]: got %h, required %h", i, {vif_a.ce_pix, obs_a()}, {1'b0, exp_vec(last)});
      end
    end
    enable_a = 1'b1;
    push_a();
    wait_ce(1'b0, 20, cyc, ok);
    e = qa.pop_front();
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("[TB] FAIL resume_delay: got %0d cycles, required 2", cyc);
    end
    n_checks++;
    if (obs_a() !== exp_vec(e)) begin
      n_fail++;
      $display("[TB] FAIL resume_pixel(%0d,%0d): got %h, required %h", e.h, e.v, obs_a(), exp_vec(e));
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bit ok;
    exp_t e;
    e = qa.pop_front();
    push_a();
    e = qa.pop_front();
    qa.push_front(e);
    while (e.h != 100) begin
      wait_ce(1'b0, 20, cyc, ok);
      e = qa.pop_front();
      if (e.h != 100) push_a();
    end
    #2;
    reset_a = 1'b1;
    #1;
    n_checks++;
    if ({vif_a.ce_pix, obs_a()} !== {1'b0, RST_VEC}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got %h, required %h", {vif_a.ce_pix, obs_a()}, {1'b0, RST_VEC});
    end
    repeat (2) @(negedge clk_vid);
    reset_a = 1'b0;
    qa.delete();
    pa_h = 0;
    pa_v = 0;
    push_a();
    wait_ce(1'b0, 20, cyc, ok);
    e = qa.pop_front();
    n_checks++;
    if (cyc !== 4) begin
      n_fail++;
      $display("[TB] FAIL restart_delay: got %0d cycles, required 4", cyc);
    end
    n_checks++;
    if (obs_a() !== exp_vec(e)) begin
      n_fail++;
      $display("[TB] FAIL restart_pixel: got %h, required %h", obs_a(), exp_vec(e));
    end
  endtask

  task automatic test_small_config();
    int cyc, fs_prev, vs_cnt, vb_cnt, blank_nz;
    bit ok;
    exp_t e;
    fs_prev  = -1;
    vs_cnt   = 0;
    vb_cnt   = 0;
    blank_nz = 0;
    @(negedge clk_vid);
    n_checks++;
    if ({vif_b.ce_pix, obs_b()} !== {1'b0, RST_VEC}) begin
      n_fail++;
      $display("[TB] FAIL small_reset: got %h, required %h", {vif_b.ce_pix, obs_b()}, {1'b0, RST_VEC});
    end
    reset_b = 1'b0;
    qb.delete();
    pb_h = 0;
    pb_v = 0;
    for (int i = 0; i < 2 * B_HT * B_VT + 2; i++) begin
      push_b();
      wait_ce(1'b1, 10, cyc, ok);
      e = qb.pop_front();
      n_checks++;
      if (cyc !== 2) begin
        n_fail++;
        $display("[TB] FAIL small_ce_spacing[%0d]: got %0d cycles, required 2", i, cyc);
      end
      n_checks++;
      if (obs_b() !== exp_vec(e)) begin
        n_fail++;
        $display("[TB] FAIL small_pixel(%0d,%0d): got %h, required %h", e.h, e.v, obs_b(), exp_vec(e));
      end
      if (i < B_HT * B_VT) begin
        if (vif_b.vs_out) vs_cnt++;
        if (vif_b.vb_out) vb_cnt++;
      end
      if ((vif_b.hb_out || vif_b.vb_out) && ({vif_b.r_out, vif_b.g_out, vif_b.b_out} != 12'd0))
        blank_nz++;
      if (vif_b.frame_start) begin
        if (fs_prev >= 0) begin
          n_checks++;
          if (i - fs_prev !== B_HT * B_VT) begin
            n_fail++;
            $display("[TB] FAIL frame_period: got %0d, required %0d", i - fs_prev, B_HT * B_VT);
          end
        end
        fs_prev = i;
      end
    end
    n_checks++;
    if (vs_cnt !== B_VS * B_HT) begin
      n_fail++;
      $display("[TB] FAIL vs_pixels: got %0d, required %0d", vs_cnt, B_VS * B_HT);
    end
    n_checks++;
    if (vb_cnt !== (B_VFP + B_VS + B_VBP) * B_HT) begin
      n_fail++;
      $display("[TB] FAIL vb_pixels: got %0d, required %0d", vb_cnt, (B_VFP + B_VS + B_VBP) * B_HT);
    end
    n_checks++;
    if (blank_nz !== 0) begin
      n_fail++;
      $display("[TB] FAIL small_blank_black: got %0d, required 0", blank_nz);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    enable_a = 1'b1;
    enable_b = 1'b1;
    test_reset();
    test_first_ce();
    test_horizontal();
    test_data_path();
    test_enable_freeze();
    test_reset_mid_frame();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 3 ms");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
